// File: rtl/fa_pkg.sv
// ----------------------------------------------------------------------------
// fa_pkg
// Shared constants for the structural full-adder slice.
//   FA_DEFAULT_WIDTH        : operand width when the adder is instantiated
//                             without overriding WIDTH (classic 1-bit cell).
//   FA_DEFAULT_RESULT_WIDTH : width of {carry, sum} for the default width.
//   fa_result_width()       : width of {carry, sum} for an arbitrary WIDTH.
// ----------------------------------------------------------------------------
package fa_pkg;

    localparam int FA_DEFAULT_WIDTH        = 1;
    localparam int FA_DEFAULT_RESULT_WIDTH = FA_DEFAULT_WIDTH + 1;

    // The carry-out is one extra bit on top of the operand width, so no
    // overflow is ever lost.
    function automatic int fa_result_width(input int width);
        return width + 1;
    endfunction

endpackage : fa_pkg

// File: rtl/fa_half_adder.sv
// ----------------------------------------------------------------------------
// fa_half_adder
// Gate-level half adder cell, the building block of each full-adder bit.
// Ports:
//   x, y : input  1  operand bits
//   s    : output 1  sum bit   (x ^ y)
//   co   : output 1  carry bit (x & y)
// ----------------------------------------------------------------------------
module fa_half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic co
);

    assign s  = x ^ y;
    assign co = x & y;

endmodule : fa_half_adder

// File: rtl/fa_structural.sv
// ----------------------------------------------------------------------------
// fa_structural
// Structural ripple-carry adder built from gate-level half-adder cells.
// WIDTH=1 gives the classic 1-bit full adder; larger WIDTH chains WIDTH
// full-adder cells with the carry rippling from bit 0 upward.
//
// There is no handshake: with REG_OUT=1 every rising clk edge captures a
// valid result of the inputs present at that edge (1-cycle latency); with
// REG_OUT=0 the outputs are purely combinational and clk/rst are ignored.
//
// Parameters:
//   WIDTH   : operand width / number of full-adder cells (>= 1)
//   REG_OUT : 1 = registered outputs, 0 = combinational outputs
// Ports:
//   clk   : input  1      rising-edge clock for the output register
//   rst   : input  1      asynchronous active-high reset of the register
//   a     : input  WIDTH  operand A
//   b     : input  WIDTH  operand B
//   c     : input  1      carry-in into bit 0
//   sum   : output WIDTH  (a + b + c) mod 2^WIDTH
//   carry : output 1      (a + b + c) >> WIDTH
// ----------------------------------------------------------------------------
module fa_structural
    import fa_pkg::*;
#(
    parameter int WIDTH   = FA_DEFAULT_WIDTH,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int RES_W = fa_result_width(WIDTH);

    // cin_chain[i] is the carry into cell i; cin_chain[WIDTH] is the
    // carry-out of the MSB cell.
    logic [WIDTH:0]   cin_chain;
    logic [WIDTH-1:0] sum_comb;

    assign cin_chain[0] = c;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_cell
            logic p;   // propagate: a ^ b
            logic g1;  // generate from the operands
            logic s;   // final sum bit
            logic g2;  // generate from propagate and incoming carry

            fa_half_adder u_ha_ab (
                .x  (a[i]),
                .y  (b[i]),
                .s  (p),
                .co (g1)
            );

            fa_half_adder u_ha_pc (
                .x  (p),
                .y  (cin_chain[i]),
                .s  (s),
                .co (g2)
            );

            // g1 and g2 are never both 1 (g2 needs p=1, which rules out
            // g1), so OR is the full carry.
            assign sum_comb[i]    = s;
            assign cin_chain[i+1] = g1 | g2;
        end
    endgenerate

    logic [RES_W-1:0] result_comb;
    assign result_comb = {cin_chain[WIDTH], sum_comb};

    generate
        if (REG_OUT) begin : g_reg
            logic [RES_W-1:0] result_q;

            // Asynchronous reset clears the result immediately and throws
            // away whatever would have been captured at the next edge.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    result_q <= '0;
                end else begin
                    result_q <= result_comb;
                end
            end

            assign sum   = result_q[WIDTH-1:0];
            assign carry = result_q[WIDTH];
        end else begin : g_comb
            // clk and rst have no function in the combinational build.
            logic unused_clk_rst;
            assign unused_clk_rst = clk | rst;

            assign sum   = result_comb[WIDTH-1:0];
            assign carry = result_comb[WIDTH];
        end
    endgenerate

endmodule : fa_structural

// File: tb/tb_fa_structural.sv
// ----------------------------------------------------------------------------
// tb_fa_structural
// Self-checking bench for fa_structural. Four instances share clk/rst:
//   u_w1  : WIDTH=1, REG_OUT=1
//   u_w1c : WIDTH=1, REG_OUT=0
//   u_w4  : WIDTH=4, REG_OUT=1
//   u_w8  : WIDTH=8, REG_OUT=1
// Expected values come from integer addition in the bench and are queued
// in exp_q when the stimulus is driven, then popped when the output is due.
// ----------------------------------------------------------------------------
module tb_fa_structural;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
    logic       s1, co1;
    logic       a1c = 1'b0, b1c = 1'b0, c1c = 1'b0;
    logic       s1c, co1c;
    logic [3:0] a4 = '0, b4 = '0;
    logic       c4 = 1'b0;
    logic [3:0] s4;
    logic       co4;
    logic [7:0] a8 = '0, b8 = '0;
    logic       c8 = 1'b0;
    logic [7:0] s8;
    logic       co8;

    fa_structural #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .sum(s1), .carry(co1)
    );
    fa_structural #(.WIDTH(1), .REG_OUT(1'b0)) u_w1c (
        .clk(clk), .rst(rst), .a(a1c), .b(b1c), .c(c1c), .sum(s1c), .carry(co1c)
    );
    fa_structural #(.WIDTH(4), .REG_OUT(1'b1)) u_w4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .c(c4), .sum(s4), .carry(co4)
    );
    fa_structural #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8), .sum(s8), .carry(co8)
    );

    // ---------------- scoreboard ----------------
    logic [8:0] exp_q[$];
    int         tests_run = 0;
    int         tests_failed = 0;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_pop(input string tag, input logic [8:0] obs);
        logic [8:0] exp;
        if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $error("FAIL %s observed=%h expected=<empty queue>", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            check(tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drive on the falling edge, expect the result just after the next
    // rising edge.
    task automatic step1(input logic a, input logic b, input logic c, input string tag);
        @(negedge clk);
        a1 = a; b1 = b; c1 = c;
        exp_q.push_back(9'(a) + 9'(b) + 9'(c));
        @(posedge clk);
        #1;
        check_pop(tag, {7'd0, co1, s1});
    endtask

    task automatic step4(input logic [3:0] a, input logic [3:0] b, input logic c, input string tag);
        @(negedge clk);
        a4 = a; b4 = b; c4 = c;
        exp_q.push_back(9'(a) + 9'(b) + 9'(c));
        @(posedge clk);
        #1;
        check_pop(tag, {4'd0, co4, s4});
    endtask

    task automatic step8(input logic [7:0] a, input logic [7:0] b, input logic c, input string tag);
        @(negedge clk);
        a8 = a; b8 = b; c8 = c;
        exp_q.push_back(9'(a) + 9'(b) + 9'(c));
        @(posedge clk);
        #1;
        check_pop(tag, {co8, s8});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset held with a=b=c=1: outputs must stay 0 across edges.
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("rst_hold_w1", {7'd0, co1, s1}, 9'd0);
        end
        check("rst_hold_w4", {4'd0, co4, s4}, 9'd0);
        check("rst_hold_w8", {co8, s8}, 9'd0);

        // Release reset: first capture on the next rising edge.
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(9'd3);
        @(posedge clk);
        #1;
        check_pop("rst_release_w1", {7'd0, co1, s1});
        a4 = '0; b4 = '0; c4 = 1'b0;
        a8 = '0; b8 = '0; c8 = 1'b0;

        // WIDTH=1 registered truth table.
        for (int v = 0; v < 8; v++) begin
            logic [2:0] abc;
            abc = 3'(v);
            step1(abc[2], abc[1], abc[0], $sformatf("tt_reg_%0d", v));
        end

        // WIDTH=1 combinational truth table, 100 time units per vector.
        for (int v = 0; v < 8; v++) begin
            logic [2:0] abc;
            abc = 3'(v);
            a1c = abc[2]; b1c = abc[1]; c1c = abc[0];
            #50;
            check($sformatf("tt_comb_%0d", v), {7'd0, co1c, s1c},
                  9'(abc[2]) + 9'(abc[1]) + 9'(abc[0]));
            #50;
        end

        // WIDTH=4 boundaries.
        step4(4'hF, 4'h0, 1'b1, "w4_full_ripple");
        step4(4'h5, 4'hA, 1'b0, "w4_alternating");
        step4(4'hF, 4'hF, 1'b1, "w4_all_ones");
        step4(4'h0, 4'h0, 1'b0, "w4_all_zeros");

        // Reset mid-stream: result 8 captured, then rst between edges.
        step4(4'h3, 4'h4, 1'b1, "w4_pre_reset");
        a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("w4_async_reset", {4'd0, co4, s4}, 9'd0);
        @(posedge clk);
        #1;
        check("w4_reset_discard", {4'd0, co4, s4}, 9'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(9'h1F);
        @(posedge clk);
        #1;
        check_pop("w4_after_reset", {4'd0, co4, s4});

        // WIDTH=8 boundaries and random regression.
        step8(8'hFF, 8'hFF, 1'b1, "w8_all_ones");
        step8(8'h00, 8'h00, 1'b0, "w8_all_zeros");
        step8(8'hFF, 8'h00, 1'b1, "w8_full_ripple");
        for (int n = 0; n < 1000; n++) begin
            step8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), $sformatf("w8_rand_%0d", n));
        end

        check("queue_drained", 9'(exp_q.size()), 9'd0);

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_fa_structural
